// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared widths and output-buffer constants for the BRAM-backed FIFO controller.
package bram_fifo_ctrl_pkg;
    localparam int ADDR_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int OBUF_DEPTH     = 3;

    localparam logic [1:0] OBUF_LAST  = 2'(OBUF_DEPTH - 1);
    localparam logic [2:0] OBUF_SLOTS = 3'(OBUF_DEPTH);

    function automatic logic [1:0] obuf_idx_inc(input logic [1:0] idx);
        return (idx == OBUF_LAST) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_out_buffer.sv
// Three-entry register FIFO with first-word-fall-through head; absorbs the RAM read latency.
module fifo_out_buffer
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            buf_count
);
    logic [DATA_WIDTH-1:0] mem_p2 [OBUF_DEPTH];
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic                  pop_ok;

    assign pop_ok = pop && (buf_count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx    <= 2'd0;
            rd_idx    <= 2'd0;
            buf_count <= 2'd0;
        end else begin
            if (push)
                wr_idx <= obuf_idx_inc(wr_idx);
            if (pop_ok)
                rd_idx <= obuf_idx_inc(rd_idx);
            case ({push, pop_ok})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Stage p2: buffered words; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_p2[wr_idx] <= din;
    end

    // Head is forced to zero when empty so reset and idle states read as 0.
    assign dout = (buf_count != 2'd0) ? mem_p2[rd_idx] : '0;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller using an external dual-port BRAM as storage, presenting a FWFT output stream.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_dpra,
    input  logic [DATA_WIDTH-1:0] ram_dpo
);
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic                  dpo_vld_p1;
    logic [1:0]            buf_count;
    logic [2:0]            credit;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;

    assign in_ready = !reset && (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign ram_we   = push;
    assign ram_a    = wr_ptr;
    assign ram_di   = in_data;
    assign ram_dpra = rd_ptr;

    // Stage p0: issue a read only when the buffer can take every word already in flight.
    assign credit   = {1'b0, buf_count} + {2'b00, dpo_vld_p1};
    assign rd_issue = (ram_count != '0) && (credit < OBUF_SLOTS);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            count      <= '0;
            dpo_vld_p1 <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, rd_issue})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            dpo_vld_p1 <= rd_issue;
        end
    end

    // Stage p1 -> p2: the RAM's registered read word enters the output buffer.
    fifo_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (dpo_vld_p1),
        .din       (ram_dpo),
        .pop       (pop),
        .dout      (out_data),
        .buf_count (buf_count)
    );

    assign out_valid = (buf_count != 2'd0);
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomized and directed bench for bram_fifo_ctrl against a queue-based reference model.
module tb_bram_fifo_ctrl;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_dpra;
    logic [DW-1:0] ram_dpo;

    logic [DW-1:0] ram [DEPTH];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference: words in order, each tagged with the clock edge that accepted it.
    byte unsigned q_data [$];
    int           q_edge [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            ram[ram_a] <= ram_di;
        ram_dpo <= ram[ram_dpra];
    end

    bram_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_dpra  (ram_dpra),
        .ram_dpo   (ram_dpo)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic rst_i, input logic iv, input logic [DW-1:0] d,
                        input logic ordy);
        bit exp_ready;
        bit exp_valid;
        reset     = rst_i;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_ready = !rst_i && (q_data.size() != DEPTH);
        exp_valid = (q_data.size() != 0) && (q_edge[0] <= edge_n - 2);
        chk("count", int'(count), q_data.size());
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("out_valid", int'(out_valid), int'(exp_valid));
        chk("ram_we", int'(ram_we), int'(iv && exp_ready));
        if (out_valid && ordy && q_data.size() != 0) begin
            chk("out_data", int'(out_data), int'(q_data[0]));
            void'(q_data.pop_front());
            void'(q_edge.pop_front());
        end
        if (iv && exp_ready) begin
            q_data.push_back(d);
            q_edge.push_back(edge_n + 1);
        end
        if (rst_i) begin
            q_data.delete();
            q_edge.delete();
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        edge_n = 2;
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_out_data", int'(out_data), 0);

        // Single word fall-through.
        step(1'b0, 1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Full-rate stream.
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b1);
            chk("stream_count_le3", int'(count <= 3), 1);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill to full, attempt one extra push, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("full_count", int'(count), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Near-full alternation to exercise pointer wrap.
        for (int i = 0; i < 2040; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, 8'($urandom), 1'b0);
            else            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_count_range", int'(count >= 2039 && count <= 2041), 1);
        end
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 20000; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        // Reset with 100 words held.
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Single-clock FIFO controller that drives an external 2048 x 8 dual-port block RAM as storage. It turns a valid/ready byte stream into RAM writes on port A. It reads back through port B, which has one cycle of read latency. A small output buffer hides that latency, so the consumer sees a first-word-fall-through valid/ready stream at full rate. The block sits between a byte producer (USB/host receive path) and the downstream consumer; the RAM itself is instantiated alongside it with both RAM clocks tied to `clk`.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: RAM address width; `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 8: word width.

Ports:
- `clk`  in  1  clock; also drives both RAM clocks.
- `reset`  in  1  reset, synchronous, active-high.
- `in_data`  in  DATA_WIDTH  write data.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO can accept; push = `in_valid & in_ready`.
- `out_data`  out  DATA_WIDTH  head-of-FIFO word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes word; pop = `out_valid & out_ready`.
- `count`  out  ADDR_WIDTH+1  words accepted and not yet popped, range 0..DEPTH.
- `ram_we`  out  1  RAM port A write enable.
- `ram_a`  out  ADDR_WIDTH  RAM port A address (write pointer).
- `ram_di`  out  DATA_WIDTH  RAM port A write data.
- `ram_dpra`  out  ADDR_WIDTH  RAM port B address (read pointer).
- `ram_dpo`  in  DATA_WIDTH  RAM port B registered read data.
- The RAM's port B write enable and data are tied to 0. The RAM's port A read output is unused.

## Operation
- Write side:
  - `ram_we = push`, `ram_a = wr_ptr`, `ram_di = in_data`.
  - `wr_ptr` increments modulo DEPTH on each push.
  - `in_ready = !reset && count != DEPTH`.
- RAM occupancy: `ram_count` holds the number of words written but not yet read from the RAM.
  - It increments on push and decrements on read issue.
  - On a simultaneous push and read issue it is unchanged.
- Read issue (combinational, from registered state only): `rd_issue = ram_count != 0 && (buf_count + dpo_valid) < 3`.
  - On issue, `rd_ptr` increments modulo DEPTH.
  - `ram_dpra = rd_ptr` at all times.
- `dpo_valid` is a register equal to the previous cycle's `rd_issue`. When it is set, `ram_dpo` holds that word.
- Output buffer: 3-entry FIFO of registers.
  - It is written from `ram_dpo` when `dpo_valid` is set.
  - `out_valid = buf_count != 0`; `out_data` = the buffer head.
  - The credit check guarantees the buffer never overflows.
- `count` increments on push and decrements on pop; it is unchanged when both happen in the same cycle.
- No read-during-write hazard: a word written at edge E is counted in `ram_count` only after E, so it cannot be read at the edge where it is written.
- The block never pushes when full (`in_ready` low), so `count` cannot exceed DEPTH.
- Any pop or push attempted while its ready/valid partner is low has no effect.

## Timing
- Reset values:
  - `wr_ptr`, `rd_ptr`, `ram_count`, `count`, `buf_count`, `dpo_valid` = 0.
  - `out_valid` = 0, `in_ready` = 0, `ram_we` = 0, `out_data` = 0.
- Reset asserted mid-operation discards all contents at the next edge. RAM contents are not cleared.
- Fall-through latency: a push at edge E into an empty FIFO gives read issue in cycle E..E+1, data in `ram_dpo` after E+1, and `out_valid` high after E+2.
- Throughput: one push and one pop per cycle sustained with no bubbles once the buffer holds at least one word.
- `count` and `in_ready` update at the same edge as the push or pop that changes them. `in_ready` drops in the cycle after the push that brings `count` to DEPTH.
- Pointer wrap: address DEPTH-1 is followed by 0, with no gap.

## Structure
- A shared package/header holds the default widths (`ADDR_WIDTH` = 11, `DATA_WIDTH` = 8) and the output buffer depth constant (3).
- One sub-module, `fifo_out_buffer`: a 3-entry register FIFO with push/pop, `buf_count` output and FWFT head. The controller keeps the pointers, counters and read-issue logic.

## Test plan
- Reset, then push 0x41 once with `out_ready` = 1 → `out_valid` rises 2 edges after the push, `out_data` = 0x41, `count` goes 1 → 0 on the pop.
- Stream 0x00..0xFF with `in_valid` and `out_ready` held at 1 → output matches in order with no idle cycles after the first word; `count` stays ≤ 3.
- With `out_ready` = 0, push 2048 bytes → `in_ready` low after the 2048th push and `count` = 2048; a further `in_valid` is ignored; draining returns all 2048 bytes in order.
- Fill to 2040, then push and pop in alternation for 5000 cycles → pointers wrap past 2047 → 0, data stays intact, `count` stays at 2040 ± 1.
- Random `in_valid`/`out_ready` (50%) for 20000 cycles against a scoreboard → no loss or duplication; `count` equals the scoreboard depth every cycle.
- Assert `reset` mid-stream with 100 words held → next cycle `out_valid` = 0, `count` = 0, `in_ready` = 0; after release, new data only.
